scic_control: RTL

- Multi-cycle control sequencer for the SCIC processor datapath (PC, IR, AC, memory, switch/LED I/O).
- Steps each instruction through fetch, decode and execute.
- Emits the per-cycle datapath strobes and handles memory wait states.
- Detects stalled memory accesses, counts retired instructions and stops the core on HALT.

---
 rtl/scic_control_if.sv | 33 +++
 rtl/scic_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scic_control_if.sv
// scic_control_if: control/datapath/memory bundle for the SCIC sequencer.
// master = sequencer side (drives strobes), slave = datapath/memory side.
interface scic_control_if #(
  parameter int OPCODE_WIDTH = 4
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    ac_zero;
  logic                    ac_neg;
  logic                    mem_ready;
  logic                    mem_read;
  logic                    mem_write;
  logic                    addr_sel;
  logic                    ir_load;
  logic                    pc_inc;
  logic                    pc_load;
  logic                    ac_load;
  logic [1:0]              ac_src;
  logic                    alu_op;
  logic                    io_read;
  logic                    io_write;

  modport master (
    input  opcode, ac_zero, ac_neg, mem_ready,
    output mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load,
           ac_load, ac_src, alu_op, io_read, io_write
  );

  modport slave (
    output opcode, ac_zero, ac_neg, mem_ready,
    input  mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load,
           ac_load, ac_src, alu_op, io_read, io_write
  );
endinterface

// File: rtl/scic_control.sv
// scic_control: multi-cycle fetch/decode/execute sequencer for the SCIC core.
// Issues datapath strobes, waits on mem_ready, aborts stalled memory accesses
// with a sticky bus_error, counts retired instructions and stops on HALT.
// Optional macro SCIC_CTRL_SINGLE_STEP_EN adds a step input and a STEP_WAIT
// state that parks the core after every retired instruction.
module scic_control #(
  parameter int OPCODE_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef SCIC_CTRL_SINGLE_STEP_EN
  input  logic                   step,
`endif
  scic_control_if.master         bus,
  output logic                   halted,
  output logic                   bus_error,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [2:0]             state
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRA   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_IN    = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
`ifdef SCIC_CTRL_SINGLE_STEP_EN
    S_HALT      = 3'd4,
    S_STEP_WAIT = 3'd5
`else
    S_HALT      = 3'd4
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [WAIT_W-1:0]       wait_cnt;

  logic       mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load;
  logic       ac_load, alu_op, io_read, io_write;
  logic [1:0] ac_src;
  logic       waiting;
  logic       timeout_now;
  logic       retire;
  logic       abort;

  // The access has run out of patience when this low-ready cycle is the last allowed one
  always_comb begin
    timeout_now = 1'b0;
    if (TIMEOUT_CYCLES != 0 && !bus.mem_ready &&
        wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1))
      timeout_now = 1'b1;
  end

  // Next-state and strobe decode; strobes are Mealy on mem_ready for memory ops
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ac_load   = 1'b0;
    ac_src    = 2'b00;
    alu_op    = 1'b0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    waiting   = 1'b0;
    retire    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        waiting  = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (op_q)
          OP_LOAD: begin
            mem_read = 1'b1;
            addr_sel = 1'b1;
            waiting  = 1'b1;
            if (bus.mem_ready) begin
              ac_load = 1'b1;
              ac_src  = 2'b01;
              retire  = 1'b1;
            end
          end
          OP_STORE: begin
            mem_write = 1'b1;
            addr_sel  = 1'b1;
            waiting   = 1'b1;
            retire    = bus.mem_ready;
          end
          OP_ADD, OP_SUB: begin
            mem_read = 1'b1;
            addr_sel = 1'b1;
            waiting  = 1'b1;
            if (bus.mem_ready) begin
              ac_load = 1'b1;
              alu_op  = (op_q == OP_SUB);
              retire  = 1'b1;
            end
          end
          OP_BRA: begin
            pc_load = 1'b1;
            retire  = 1'b1;
          end
          OP_BRZ: begin
            pc_load = bus.ac_zero;
            retire  = 1'b1;
          end
          OP_BRN: begin
            pc_load = bus.ac_neg;
            retire  = 1'b1;
          end
          OP_IN: begin
            io_read = 1'b1;
            ac_load = 1'b1;
            ac_src  = 2'b10;
            retire  = 1'b1;
          end
          OP_OUT: begin
            io_write = 1'b1;
            retire   = 1'b1;
          end
          OP_HALT: state_d = S_HALT;
          default: retire = 1'b1;
        endcase
        if (retire) begin
`ifdef SCIC_CTRL_SINGLE_STEP_EN
          state_d = S_STEP_WAIT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: state_d = S_HALT;
`ifdef SCIC_CTRL_SINGLE_STEP_EN
      S_STEP_WAIT: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_RST;
    endcase
    if (waiting && timeout_now) begin
      abort   = 1'b1;
      state_d = S_HALT;
    end
  end

  // State, decoded opcode, wait counter, sticky error and retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      op_q        <= '0;
      wait_cnt    <= '0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= bus.opcode;
      if (TIMEOUT_CYCLES != 0 && waiting && !bus.mem_ready && state_d == state_q)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (abort)
        bus_error <= 1'b1;
      if (retire)
        instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.addr_sel  = addr_sel;
  assign bus.ir_load   = ir_load;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_load   = pc_load;
  assign bus.ac_load   = ac_load;
  assign bus.ac_src    = ac_src;
  assign bus.alu_op    = alu_op;
  assign bus.io_read   = io_read;
  assign bus.io_write  = io_write;

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule
